// File: rtl/div_unit_if.sv
// Request/response bundle for the iterative divider.
// The requester drives the master side; the divider is the slave.
interface div_unit_if #(
    parameter int BitWidth = 32
);
    logic                start;
    logic                is_signed;
    logic [BitWidth-1:0] a;
    logic [BitWidth-1:0] b;
    logic                busy;
    logic                done;
    logic [BitWidth-1:0] quotient;
    logic [BitWidth-1:0] remainder;
    logic                div_by_zero;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_unit.sv
// Restoring divider for DIV/DIVU/REM/REMU, one trial subtraction per clock.
// Divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
    parameter int BitWidth = 32
) (
    input logic      clk,
    input logic      rst_n,
    div_unit_if.slave bus
);
    localparam int CntW = (BitWidth > 2) ? $clog2(BitWidth) : 1;

    typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BitWidth-1:0] r_rem;
    logic [BitWidth-1:0] r_quo;
    logic [BitWidth-1:0] r_dvs;
    logic [BitWidth-1:0] r_a;
    logic [CntW-1:0]     r_cnt;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_dz;
    logic                r_ovf;
    logic [BitWidth-1:0] r_quot_o;
    logic [BitWidth-1:0] r_rem_o;
    logic                r_dz_o;
    logic                r_done;

    logic                w_a_neg;
    logic                w_b_neg;
    logic [BitWidth-1:0] w_abs_a;
    logic [BitWidth-1:0] w_abs_b;
    logic [BitWidth-1:0] w_min;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic [BitWidth:0]   w_shift;
    logic [BitWidth:0]   w_diff;
    logic                w_busy;
    logic                w_load;
    logic                w_step;
    logic                w_fin;

    assign w_min     = {1'b1, {(BitWidth-1){1'b0}}};
    assign w_a_neg   = bus.is_signed & bus.a[BitWidth-1];
    assign w_b_neg   = bus.is_signed & bus.b[BitWidth-1];
    assign w_abs_a   = w_a_neg ? -bus.a : bus.a;
    assign w_abs_b   = w_b_neg ? -bus.b : bus.b;
    assign w_b_zero  = (bus.b == '0);
    assign w_ovf     = bus.is_signed & (bus.a == w_min) & (bus.b == '1);
    assign w_special = w_b_zero | w_ovf;

    // Width BitWidth+1 so the borrow bit tells whether the trial fits
    assign w_shift = {r_rem, r_quo[BitWidth-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) w_next = w_special ? FINISH : DIVIDE;
            end
            DIVIDE: begin
                if (r_cnt == CntW'(BitWidth-1)) w_next = FINISH;
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        unique case (r_state)
            IDLE:    w_load = bus.start;
            DIVIDE: begin
                w_busy = 1'b1;
                w_step = 1'b1;
            end
            FINISH: begin
                w_busy = 1'b1;
                w_fin  = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_a     <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.a;
            r_dz    <= w_b_zero;
            r_ovf   <= w_ovf;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + CntW'(1);
            r_quo <= {r_quo[BitWidth-2:0], ~w_diff[BitWidth]};
            r_rem <= w_diff[BitWidth] ? w_shift[BitWidth-1:0]
                                      : w_diff[BitWidth-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_quot_o <= '0;
            r_rem_o  <= '0;
            r_dz_o   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                unique case (1'b1)
                    r_dz: begin
                        r_quot_o <= '1;
                        r_rem_o  <= r_a;
                        r_dz_o   <= 1'b1;
                    end
                    r_ovf: begin
                        r_quot_o <= r_a;
                        r_rem_o  <= '0;
                        r_dz_o   <= 1'b0;
                    end
                    default: begin
                        r_quot_o <= r_neg_q ? -r_quo : r_quo;
                        r_rem_o  <= r_neg_r ? -r_rem : r_rem;
                        r_dz_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot_o;
    assign bus.remainder   = r_rem_o;
    assign bus.div_by_zero = r_dz_o;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit at BitWidth=8: directed cases,
// handshake and reset corners, then a randomized sweep.
module tb_div_unit;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t e;
    logic [W-1:0] lq;
    logic [W-1:0] lr;
    logic         ldz;

    div_unit_if #(.BitWidth(W)) bus ();

    div_unit #(.BitWidth(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // RISC-V M semantics straight from integer arithmetic
    task automatic ref_div(input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, output exp_t x,
                           output int lat);
        int sa;
        int sb_;
        x.due = 0;
        if (b == 0) begin
            x.q = '1; x.r = a; x.dz = 1'b1; lat = 1;
        end else if (s) begin
            sa  = int'($signed(a));
            sb_ = int'($signed(b));
            x.dz = 1'b0;
            if (sa == -(2 ** (W - 1)) && sb_ == -1) begin
                x.q = a; x.r = '0; lat = 1;
            end else begin
                x.q = W'(sa / sb_);
                x.r = W'(sa % sb_);
                lat = W + 1;
            end
        end else begin
            x.q = a / b; x.r = a % b; x.dz = 1'b0; lat = W + 1;
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] ia,
                         input logic [W-1:0] ib);
        exp_t x;
        int   lat;
        int   n;
        bus.is_signed = s;
        bus.a         = ia;
        bus.b         = ib;
        bus.start     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 200);
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout busy=%0b exp=0", bus.busy);
            bus.start = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        ref_div(s, ia, ib, x, lat);
        x.due = cyc + lat;
        sb.push_back(x);
        bus.start     = 1'b0;
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.is_signed = 1'($urandom);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 9))
            0: return '0;
            1: return W'(1);
            2: return '1;
            3: return {1'b0, {(W-1){1'b1}}};
            4: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            lq  = '0;
            lr  = '0;
            ldz = 1'b0;
        end else if (bus.done) begin
            chk("busy_in_done", bus.busy, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done q=%0h r=%0h exp=none",
                         bus.quotient, bus.remainder);
            end else begin
                e = sb.pop_front();
                chk("quotient", bus.quotient, e.q);
                chk("remainder", bus.remainder, e.r);
                chk("div_by_zero", bus.div_by_zero, e.dz);
                chk("latency", cyc, e.due);
            end
            lq  = bus.quotient;
            lr  = bus.remainder;
            ldz = bus.div_by_zero;
        end else begin
            chk("hold_q", bus.quotient, lq);
            chk("hold_r", bus.remainder, lr);
            chk("hold_dz", bus.div_by_zero, ldz);
            if (sb.size() != 0) chk("busy_high", bus.busy, 1);
        end
    end

    initial begin
        int n;
        cyc           = 0;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b0, 8'd100, 8'd7);
        issue(1'b1, 8'hF9, 8'h02);
        issue(1'b1, 8'h07, 8'hFE);
        issue(1'b0, 8'd5, 8'd0);
        issue(1'b1, 8'h80, 8'hFF);

        // second strobe lands while busy and must be dropped
        issue(1'b0, 8'd200, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'd9;
        bus.b     = 8'd9;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        issue(1'b0, 8'd9, 8'd9);

        issue(1'b0, 8'd255, 8'd16);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_q", bus.quotient, 0);
        chk("abort_r", bus.remainder, 0);
        chk("abort_dz", bus.div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(1'b0, 8'd255, 8'd16);

        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 12)) @(posedge clk);
            #1;
            issue(1'($urandom), pick(), pick());
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
